// File: rtl/char_spawner.sv
// Spawn scheduler: random letter/column/speed, round-robin slot allocation, valid/ready hand-off.
// Optional `SPAWN_NO_REPEAT_COL_EN keeps consecutive spawns out of the same column.
module char_spawner #(
  parameter int unsigned SPAWN_DIV = 50_000_000,
  parameter int unsigned SLOTS     = 32,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [1:0]               level,
  input  logic                     rel_valid,
  input  logic [$clog2(SLOTS)-1:0] rel_slot,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [$clog2(SLOTS)-1:0] wr_slot,
  output logic [7:0]               wr_ch,
  output logic [9:0]               wr_x,
  output logic [3:0]               wr_speed,
  output logic [$clog2(SLOTS):0]   active_cnt,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned   SW        = $clog2(SLOTS);
  localparam logic [15:0]   SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [SW:0]   LAST_SCAN = (SW+1)'(SLOTS - 1);
  localparam logic [SLOTS-1:0] ONE    = {{(SLOTS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, WRITE = 2'd2} state_t;

  state_t            state_q;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [31:0]       tick_cnt_q, period_m1;
  logic [1:0]        level_q;
  logic              pending_q, pending_d;
  logic [SLOTS-1:0]  occ_q, occ_d, rel_mask, set_mask;
  logic [SW-1:0]     rr_ptr_q, scan_idx_q, wr_slot_q;
  logic [SW:0]       scan_cnt_q, active_q;
  logic              wr_valid_q;
  logic [7:0]        wr_ch_q, drop_q, drop_d;
  logic [9:0]        wr_x_q;
  logic [3:0]        wr_speed_q;
  logic [8:0]        drop_sum;
  logic              tick, overflow, scan_full;
  logic [4:0]        ch_r;
  logic [6:0]        col_raw, col_new;

  function automatic logic [SW:0] popcount(input logic [SLOTS-1:0] v);
    logic [SW:0] n;
    n = {(SW+1){1'b0}};
    for (int i = 0; i < SLOTS; i++) n = n + {{SW{1'b0}}, v[i]};
    return n;
  endfunction

  assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign period_m1 = 32'(SPAWN_DIV >> level_q) - 32'd1;
  assign tick      = enable && (tick_cnt_q == period_m1);

  // A tick that finds the FSM busy is parked in pending; a second one is lost.
  assign overflow  = tick && pending_q;
  assign pending_d = enable && (state_q != IDLE) && (pending_q || tick);
  assign scan_full = (state_q == SCAN) && occ_q[scan_idx_q] && (scan_cnt_q == LAST_SCAN);
  assign drop_sum  = {1'b0, drop_q} + {8'd0, overflow} + {8'd0, scan_full};
  assign drop_d    = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  // The slot being offered to the writer cannot be released underneath it.
  assign rel_mask = (rel_valid && !((state_q == WRITE) && (rel_slot == wr_slot_q))) ?
                    (ONE << rel_slot) : {SLOTS{1'b0}};
  assign set_mask = ((state_q == SCAN) && !occ_q[scan_idx_q]) ? (ONE << scan_idx_q) : {SLOTS{1'b0}};
  assign occ_d    = (occ_q & ~rel_mask) | set_mask;

  assign ch_r    = (lfsr_q[4:0] >= 5'd26) ? (lfsr_q[4:0] - 5'd26) : lfsr_q[4:0];
  assign col_raw = (lfsr_q[11:5] >= 7'd80) ? (lfsr_q[11:5] - 7'd80) : lfsr_q[11:5];

`ifdef SPAWN_NO_REPEAT_COL_EN
  logic [6:0] last_col_q;
  assign col_new = (col_raw == last_col_q) ? ((col_raw == 7'd79) ? 7'd0 : (col_raw + 7'd1)) : col_raw;

  // Column of the last entry actually handed to the writer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_col_q <= 7'h7F;
    end else if ((state_q == WRITE) && wr_ready) begin
      last_col_q <= wr_x_q[9:3];
    end else begin
      last_col_q <= last_col_q;
    end
  end
`else
  assign col_new = col_raw;
`endif

  // Free-running state, tick counter, spawn FSM and its registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q     <= SEED_EFF;
      tick_cnt_q <= 32'd0;
      level_q    <= 2'd0;
      pending_q  <= 1'b0;
      occ_q      <= {SLOTS{1'b0}};
      active_q   <= {(SW+1){1'b0}};
      drop_q     <= 8'd0;
      state_q    <= IDLE;
      rr_ptr_q   <= {SW{1'b0}};
      scan_idx_q <= {SW{1'b0}};
      scan_cnt_q <= {(SW+1){1'b0}};
      wr_valid_q <= 1'b0;
      wr_slot_q  <= {SW{1'b0}};
      wr_ch_q    <= 8'd0;
      wr_x_q     <= 10'd0;
      wr_speed_q <= 4'd0;
    end else begin
      lfsr_q    <= lfsr_d;
      pending_q <= pending_d;
      occ_q     <= occ_d;
      active_q  <= popcount(occ_q);
      drop_q    <= drop_d;
      // Level is only sampled at a period boundary (or while stopped).
      if (!enable || tick) begin
        tick_cnt_q <= 32'd0;
        level_q    <= level;
      end else begin
        tick_cnt_q <= tick_cnt_q + 32'd1;
      end
      case (state_q)
        IDLE: begin
          if (enable && (tick || pending_q)) begin
            wr_ch_q    <= 8'h41 + {3'b000, ch_r};
            wr_x_q     <= {col_new, 3'b000};
            wr_speed_q <= {1'b0, lfsr_q[14:12]} + 4'd1;
            scan_idx_q <= rr_ptr_q;
            scan_cnt_q <= {(SW+1){1'b0}};
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          if (!occ_q[scan_idx_q]) begin
            wr_slot_q  <= scan_idx_q;
            wr_valid_q <= 1'b1;
            state_q    <= WRITE;
          end else if (scan_cnt_q == LAST_SCAN) begin
            state_q <= IDLE;
          end else begin
            scan_idx_q <= scan_idx_q + {{(SW-1){1'b0}}, 1'b1};
            scan_cnt_q <= scan_cnt_q + {{SW{1'b0}}, 1'b1};
          end
        end
        WRITE: begin
          if (wr_ready) begin
            wr_valid_q <= 1'b0;
            rr_ptr_q   <= wr_slot_q + {{(SW-1){1'b0}}, 1'b1};
            state_q    <= IDLE;
          end
        end
        default: begin
          wr_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign wr_valid   = wr_valid_q;
  assign wr_slot    = wr_slot_q;
  assign wr_ch      = wr_ch_q;
  assign wr_x       = wr_x_q;
  assign wr_speed   = wr_speed_q;
  assign active_cnt = active_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_char_spawner.sv
// Directed self-checking bench for char_spawner (SPAWN_DIV=16, SLOTS=4).
`timescale 1ns/1ps
module tb_char_spawner;

`ifdef SPAWN_NO_REPEAT_COL_EN
  localparam bit NOREP = 1'b1;
`else
  localparam bit NOREP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] level = 2'd0;
  logic       rel_valid = 1'b0;
  logic [1:0] rel_slot = 2'd0;
  logic       wr_ready = 1'b0;
  logic       wr_valid;
  logic [1:0] wr_slot;
  logic [7:0] wr_ch;
  logic [9:0] wr_x;
  logic [3:0] wr_speed;
  logic [2:0] active_cnt;
  logic [7:0] drop_cnt;

  int checks = 0;
  int failures = 0;
  int cyc;
  logic [15:0] lfsr_m;
  logic [15:0] hist [0:4095];
  logic [6:0]  last_col_m = 7'h7F;
  int t_base;

  char_spawner #(.SPAWN_DIV(16), .SLOTS(4), .SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .level(level),
    .rel_valid(rel_valid), .rel_slot(rel_slot),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_slot(wr_slot),
    .wr_ch(wr_ch), .wr_x(wr_x), .wr_speed(wr_speed),
    .active_cnt(active_cnt), .drop_cnt(drop_cnt)
  );

  always #10 clk = ~clk;

  // Reference LFSR and cycle count, restarted by the same reset as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc    <= 0;
      lfsr_m <= 16'hACE1;
    end else begin
      cyc    <= cyc + 1;
      lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end
  end

  always @(negedge clk) hist[cyc % 4096] = lfsr_m;

  function automatic logic [7:0] exp_ch(input logic [15:0] l);
    logic [4:0] r;
    r = l[4:0];
    if (r >= 5'd26) r = r - 5'd26;
    return 8'h41 + {3'b000, r};
  endfunction

  function automatic logic [9:0] exp_x(input logic [15:0] l, input logic [6:0] last);
    logic [6:0] c;
    c = l[11:5];
    if (c >= 7'd80) c = c - 7'd80;
    if (NOREP && (c == last)) c = (c == 7'd79) ? 7'd0 : c + 7'd1;
    return {c, 3'b000};
  endfunction

  function automatic logic [3:0] exp_speed(input logic [15:0] l);
    return {1'b0, l[14:12]} + 4'd1;
  endfunction

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic test_reset;
    checks++;
    if ({wr_valid, wr_slot, wr_ch, wr_x, wr_speed, active_cnt, drop_cnt} !== 36'd0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b s=%0d ch=%h x=%0d sp=%0d act=%0d drop=%0d want all 0",
               wr_valid, wr_slot, wr_ch, wr_x, wr_speed, active_cnt, drop_cnt);
    end
  endtask

  task automatic test_fill;
    int e0, t;
    logic [15:0] l;
    wr_ready = 1'b1;
    level = 2'd0;
    @(negedge clk);
    enable = 1'b1;
    e0 = cyc;
    for (int k = 0; k < 4; k++) begin
      t = e0 + 15 + 16 * k;
      wait_until(t + 1);
      checks++;
      if (wr_valid !== 1'b0) begin
        failures++; $display("FAIL fill_early[%0d] got valid=%b want 0", k, wr_valid);
      end
      @(negedge clk);
      l = hist[t % 4096];
      checks++;
      if (wr_valid !== 1'b1 || wr_slot !== 2'(k)) begin
        failures++; $display("FAIL fill_slot[%0d] got valid=%b slot=%0d want 1/%0d", k, wr_valid, wr_slot, k);
      end
      checks++;
      if (wr_ch !== exp_ch(l) || wr_x !== exp_x(l, last_col_m) || wr_speed !== exp_speed(l)) begin
        failures++;
        $display("FAIL fill_fields[%0d] got ch=%h x=%0d sp=%0d want ch=%h x=%0d sp=%0d", k,
                 wr_ch, wr_x, wr_speed, exp_ch(l), exp_x(l, last_col_m), exp_speed(l));
      end
      last_col_m = exp_x(l, last_col_m) >> 3;
    end
    t_base = e0 + 15 + 64;
    wait_until(t_base + 2);
    checks++;
    if (wr_valid !== 1'b0) begin
      failures++; $display("FAIL full_no_write got valid=%b want 0", wr_valid);
    end
    wait_until(t_base + 6);
    checks++;
    if (drop_cnt !== 8'd1 || active_cnt !== 3'd4) begin
      failures++; $display("FAIL full_drop got drop=%0d act=%0d want 1/4", drop_cnt, active_cnt);
    end
  endtask

  task automatic test_release;
    int t5;
    logic [15:0] l;
    t5 = t_base + 16;
    wait_until(t_base + 8);
    rel_valid = 1'b1;
    rel_slot = 2'd2;
    @(negedge clk);
    rel_valid = 1'b0;
    wait_until(t_base + 10);
    checks++;
    if (active_cnt !== 3'd3) begin
      failures++; $display("FAIL release_active got %0d want 3", active_cnt);
    end
    wait_until(t5 + 3);
    checks++;
    if (wr_valid !== 1'b0) begin
      failures++; $display("FAIL release_latency got valid=%b want 0", wr_valid);
    end
    @(negedge clk);
    l = hist[t5 % 4096];
    checks++;
    if (wr_valid !== 1'b1 || wr_slot !== 2'd2) begin
      failures++; $display("FAIL release_slot got valid=%b slot=%0d want 1/2", wr_valid, wr_slot);
    end
    checks++;
    if (wr_ch !== exp_ch(l) || wr_x !== exp_x(l, last_col_m) || wr_speed !== exp_speed(l)) begin
      failures++;
      $display("FAIL release_fields got ch=%h x=%0d sp=%0d want ch=%h x=%0d sp=%0d",
               wr_ch, wr_x, wr_speed, exp_ch(l), exp_x(l, last_col_m), exp_speed(l));
    end
    last_col_m = exp_x(l, last_col_m) >> 3;
    wait_until(t5 + 6);
    checks++;
    if (active_cnt !== 3'd4 || drop_cnt !== 8'd1) begin
      failures++; $display("FAIL release_refill got act=%0d drop=%0d want 4/1", active_cnt, drop_cnt);
    end
    t_base = t5;
  endtask

  task automatic test_stall;
    int t6;
    logic [15:0] l;
    logic [23:0] held;
    t6 = t_base + 16;
    rel_valid = 1'b1;
    rel_slot = 2'd0;
    @(negedge clk);
    rel_slot = 2'd1;
    @(negedge clk);
    rel_valid = 1'b0;
    wr_ready = 1'b0;
    wait_until(t6 + 3);
    l = hist[t6 % 4096];
    checks++;
    if (wr_valid !== 1'b1 || wr_slot !== 2'd0 || wr_ch !== exp_ch(l) || wr_x !== exp_x(l, last_col_m) ||
        wr_speed !== exp_speed(l)) begin
      failures++;
      $display("FAIL stall_first got v=%b s=%0d ch=%h x=%0d sp=%0d want 1/0/%h/%0d/%0d", wr_valid, wr_slot,
               wr_ch, wr_x, wr_speed, exp_ch(l), exp_x(l, last_col_m), exp_speed(l));
    end
    held = {exp_ch(l), exp_x(l, last_col_m), exp_speed(l), 2'd0};
    last_col_m = exp_x(l, last_col_m) >> 3;
    for (int c = t6 + 4; c <= t6 + 42; c++) begin
      @(negedge clk);
      checks++;
      if (wr_valid !== 1'b1 || {wr_ch, wr_x, wr_speed, wr_slot} !== held) begin
        failures++;
        $display("FAIL stall_hold[%0d] got v=%b ch=%h x=%0d sp=%0d s=%0d", c - t6, wr_valid, wr_ch, wr_x,
                 wr_speed, wr_slot);
      end
    end
    checks++;
    if (drop_cnt !== 8'd2 || active_cnt !== 3'd3) begin
      failures++; $display("FAIL stall_drop got drop=%0d act=%0d want 2/3", drop_cnt, active_cnt);
    end
    wr_ready = 1'b1;
    wait_until(t6 + 44);
    checks++;
    if (wr_valid !== 1'b0) begin
      failures++; $display("FAIL stall_release got valid=%b want 0", wr_valid);
    end
    @(negedge clk);
    l = hist[(t6 + 43) % 4096];
    checks++;
    if (wr_valid !== 1'b1 || wr_slot !== 2'd1 || wr_ch !== exp_ch(l) || wr_x !== exp_x(l, last_col_m) ||
        wr_speed !== exp_speed(l)) begin
      failures++;
      $display("FAIL stall_pending got v=%b s=%0d ch=%h x=%0d sp=%0d want 1/1/%h/%0d/%0d", wr_valid, wr_slot,
               wr_ch, wr_x, wr_speed, exp_ch(l), exp_x(l, last_col_m), exp_speed(l));
    end
  endtask

  task automatic test_level;
    int e, t;
    logic [15:0] l;
    int tk [0:3];
    enable = 1'b0;
    level = 2'd2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_col_m = 7'h7F;
    checks++;
    if (drop_cnt !== 8'd0 || active_cnt !== 3'd0 || wr_valid !== 1'b0) begin
      failures++; $display("FAIL level_reset got drop=%0d act=%0d v=%b want 0/0/0", drop_cnt, active_cnt, wr_valid);
    end
    @(negedge clk);
    enable = 1'b1;
    wr_ready = 1'b1;
    e = cyc;
    tk[0] = e + 3; tk[1] = e + 7; tk[2] = e + 11; tk[3] = e + 27;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        wait_until(e + 8);
        level = 2'd0;
      end
      if (k == 3) begin
        wait_until(e + 17);
        checks++;
        if (wr_valid !== 1'b0) begin
          failures++; $display("FAIL level_hold17 got valid=%b want 0", wr_valid);
        end
        wait_until(e + 20);
        wr_ready = 1'b0;
        wait_until(e + 21);
        checks++;
        if (wr_valid !== 1'b0) begin
          failures++; $display("FAIL level_hold21 got valid=%b want 0", wr_valid);
        end
      end
      t = tk[k];
      wait_until(t + 2);
      l = hist[t % 4096];
      checks++;
      if (wr_valid !== 1'b1 || wr_slot !== 2'(k) || wr_ch !== exp_ch(l) || wr_x !== exp_x(l, last_col_m) ||
          wr_speed !== exp_speed(l)) begin
        failures++;
        $display("FAIL level_spawn[%0d] got v=%b s=%0d ch=%h x=%0d sp=%0d want 1/%0d/%h/%0d/%0d", k, wr_valid,
                 wr_slot, wr_ch, wr_x, wr_speed, k, exp_ch(l), exp_x(l, last_col_m), exp_speed(l));
      end
      last_col_m = exp_x(l, last_col_m) >> 3;
    end
    t_base = e;
  endtask

  task automatic test_async_reset;
    wait_until(t_base + 30);
    checks++;
    if (wr_valid !== 1'b1 || active_cnt !== 3'd4) begin
      failures++; $display("FAIL areset_pre got v=%b act=%0d want 1/4", wr_valid, active_cnt);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (wr_valid !== 1'b0 || active_cnt !== 3'd0 || drop_cnt !== 8'd0 || wr_slot !== 2'd0) begin
      failures++;
      $display("FAIL areset_clear got v=%b act=%0d drop=%0d s=%0d want 0/0/0/0", wr_valid, active_cnt, drop_cnt,
               wr_slot);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random_sweep;
    bit abort;
    bit have_prev;
    logic [9:0] prev_x;
    logic [1:0] slot;
    abort = 1'b0;
    have_prev = 1'b0;
    prev_x = 10'd0;
    enable = 1'b0;
    level = 2'd3;
    wr_ready = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 10000 && !abort; i++) begin
      int w;
      w = 0;
      while (wr_valid !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (wr_valid !== 1'b1) begin
        failures++; $display("FAIL sweep_timeout[%0d] got valid=%b want 1", i, wr_valid);
        abort = 1'b1;
      end else begin
        checks++;
        if (wr_ch < 8'h41 || wr_ch > 8'h5A) begin
          failures++; $display("FAIL sweep_ch[%0d] got %h want 41..5A", i, wr_ch);
        end
        checks++;
        if (wr_x > 10'd632 || wr_x[2:0] !== 3'd0) begin
          failures++; $display("FAIL sweep_x[%0d] got %0d want <=632 and multiple of 8", i, wr_x);
        end
        checks++;
        if (wr_speed < 4'd1 || wr_speed > 4'd8) begin
          failures++; $display("FAIL sweep_speed[%0d] got %0d want 1..8", i, wr_speed);
        end
        if (NOREP && have_prev) begin
          checks++;
          if (wr_x === prev_x) begin
            failures++; $display("FAIL sweep_repeat[%0d] got x=%0d want different from %0d", i, wr_x, prev_x);
          end
        end
        have_prev = 1'b1;
        prev_x = wr_x;
        slot = wr_slot;
        @(negedge clk);
        rel_valid = 1'b1;
        rel_slot = slot;
        @(negedge clk);
        rel_valid = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset;
    test_fill;
    test_release;
    test_stall;
    test_level;
    test_async_reset;
    test_random_sweep;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/char_spawner.md
# char_spawner

Spawn scheduler for the falling-character typing game: periodically picks a random capital letter, column and fall speed, allocates a free slot in the on-screen character table, and hands the new entry to the character-RAM/offset-table writer through a valid/ready handshake. Sits directly upstream of the display stage, replacing the free-running once-per-second generator. The game logic releases slots through a release port when a character is typed or falls off screen.

## Interface
- `SPAWN_DIV`, default 50_000_000: base spawn period in `clk` cycles (1 s at 50 MHz).
- `SLOTS`, default 32: character table entries; power of two, 2..64.
- `SEED`, default 16'hACE1: LFSR reset value; 0 is replaced by 16'h0001.

- `clk`  in  1  system clock (CLOCK_50 domain).
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  spawning allowed (game running).
- `level`  in  2  difficulty; spawn period = `SPAWN_DIV >> level`.
- `rel_valid`  in  1  release request, one-cycle pulse.
- `rel_slot`  in  log2(SLOTS)  slot to release.
- `wr_valid`  out  1  new entry present.
- `wr_ready`  in  1  writer accepts entry.
- `wr_slot`  out  log2(SLOTS)  allocated slot.
- `wr_ch`  out  8  ASCII code, 8'h41..8'h5A.
- `wr_x`  out  10  pixel x, column*8, 0..632.
- `wr_speed`  out  4  fall speed, 1..8.
- `active_cnt`  out  log2(SLOTS)+1  occupied slots.
- `drop_cnt`  out  8  spawns lost (table full or tick overflow), saturating at 255.

## Operation
- LFSR: 16-bit Galois, taps 16'hB400, advances every cycle when out of reset.
- Tick counter: counts 0..(SPAWN_DIV>>level)-1 while `enable`; one-cycle tick on wrap. `enable` low holds the counter at 0 and clears `pending`. A `level` change takes effect at the next wrap.
- `pending` flag: set by a tick when the FSM is not IDLE. A tick while `pending` is already set is dropped and increments `drop_cnt`.
- FSM states:
  - IDLE: on a tick or `pending` (with `enable` high), clears `pending`, latches the random fields, sets scan index = `rr_ptr`, and goes to SCAN.
  - SCAN: checks one slot per cycle. A free slot is latched into `wr_slot`, marked occupied, and the FSM goes to WRITE. If SLOTS consecutive occupied slots are seen, `drop_cnt` increments and the FSM returns to IDLE.
  - WRITE: `wr_valid`=1 with all `wr_*` stable. When `wr_ready` is high, the FSM goes to IDLE and sets `rr_ptr` = `wr_slot`+1 (wraps mod SLOTS).
- Field derivation from LFSR bits at capture:
  - char r=lfsr[4:0]: if r≥26, subtract 26; `wr_ch` = 8'h41+r.
  - column c=lfsr[11:5]: if c≥80, subtract 80; `wr_x` = c<<3.
  - `wr_speed` = lfsr[14:12]+1.
- Release: `rel_valid` clears occ[`rel_slot`]. Releasing an already-free slot is ignored. Releasing the slot currently in WRITE is ignored. Release and allocation in the same cycle apply independently to different slots.
- `active_cnt` = popcount of the occupancy vector, registered.
- Leaving `enable` low mid-operation does not abort SCAN or WRITE; the current entry completes.

## Timing
- Reset values:
  - `wr_valid`=0; `wr_slot`, `wr_ch`, `wr_x`, `wr_speed` = 0.
  - `active_cnt`=0, `drop_cnt`=0; all slots free.
  - `rr_ptr`=0, `pending`=0, FSM in IDLE.
- All outputs are registered.
- Latency: tick at cycle T, SCAN at T+1. If the first scanned slot is free, `wr_valid` rises at T+2. Each occupied slot skipped adds 1 cycle.
- Handshake: `wr_valid` never drops without `wr_ready`. The transfer completes on the cycle where both are high. Back-to-back entries are separated by at least 2 idle cycles.
- The occupancy bit is visible in `active_cnt` one cycle after it is set or cleared.

## Configuration
- `SPAWN_NO_REPEAT_COL_EN`:
  - Defined: the spawner keeps the last spawned column. If the new column equals it, the column becomes (c+1) mod 80, so two consecutive spawns never share a column.
  - Undefined: the column is used as derived; the register and comparator are absent.

## Test plan
- SPAWN_DIV=16, SLOTS=4, level=0, `wr_ready`=1, no release → entries at slots 0,1,2,3, with `wr_valid` at cycle tick+2 each. The 5th tick increments `drop_cnt` to 1; `active_cnt`=4.
- Same setup, then `rel_valid` with `rel_slot`=2 → the next spawn fills slot 2 and `active_cnt` returns to 4.
- Hold `wr_ready`=0 for 40 cycles across 3 ticks → outputs stay stable, `pending` absorbs 1 tick, 1 drop is counted. Raising `wr_ready` completes the transfer; the pending spawn follows.
- level=2 with SPAWN_DIV=16 → ticks every 4 cycles; `level`=0 written mid-count takes effect after the current wrap.
- Assert `rst_n` low during WRITE → `wr_valid`=0 immediately (asynchronous), and all counters and occupancy clear.
- Randomness sweep over 10,000 spawns → `wr_ch` always in 8'h41..8'h5A, `wr_x` ≤632 and a multiple of 8, `wr_speed` in 1..8. With `SPAWN_NO_REPEAT_COL_EN` defined, no two consecutive equal `wr_x`.
